// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, parity polarity codes and default widths.
// The TX parity generator uses the same parity encoding.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  localparam logic EVEN_PARITY = 1'b0;
  localparam logic ODD_PARITY  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_PRESC_W    = 6;
  localparam int SYNC_STAGES        = 2;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter would append, given the XOR of the payload.
  function automatic logic exp_parity(input logic typ, input logic payload_xor);
    logic p;
    case (typ)
      EVEN_PARITY: p = payload_xor;
      ODD_PARITY:  p = ~payload_xor;
      default:     p = payload_xor;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-flop synchronizer, per-bit oversample counter and a
// 3-sample majority vote around mid-bit.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESC_W = DEFAULT_PRESC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rx_in,
  input  logic               cnt_clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               rx_s,
  output logic [PRESC_W-1:0] edge_cnt,
  output logic               bit_val,
  output logic               bit_rdy,
  output logic               bit_end
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [PRESC_W-1:0]     edge_cnt_q, edge_cnt_d;
  logic                   samp_lo_q, samp_lo_d;
  logic                   samp_mid_q, samp_mid_d;
  logic [PRESC_W-1:0]     half, mid_lo, mid_hi, last;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx_in};
    half   = presc >> 1;
    mid_lo = half - PRESC_W'(1);
    mid_hi = half + PRESC_W'(1);
    last   = presc - PRESC_W'(1);

    edge_cnt_d = edge_cnt_q + PRESC_W'(1);
    if (cnt_clr || (edge_cnt_q == last)) begin
      edge_cnt_d = '0;
    end

    samp_lo_d  = samp_lo_q;
    samp_mid_d = samp_mid_q;
    if (edge_cnt_q == mid_lo) samp_lo_d  = sync_q[SYNC_STAGES-1];
    if (edge_cnt_q == half)   samp_mid_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer resets to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '1;
      edge_cnt_q <= '0;
      samp_lo_q  <= 1'b1;
      samp_mid_q <= 1'b1;
    end else begin
      sync_q     <= sync_d;
      edge_cnt_q <= edge_cnt_d;
      samp_lo_q  <= samp_lo_d;
      samp_mid_q <= samp_mid_d;
    end
  end

  // Third sample is the live synchronized line, so the vote resolves at mid+1.
  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign edge_cnt = edge_cnt_q;
  assign bit_val  = maj3(samp_lo_q, samp_mid_q, sync_q[SYNC_STAGES-1]);
  assign bit_rdy  = (edge_cnt_q == mid_hi);
  assign bit_end  = (edge_cnt_q == last);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame engine: start/data/parity/stop sequencing on top of the
// sampler, with registered payload and single-cycle result pulses.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int PRESC_W    = DEFAULT_PRESC_W
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESC_W-1:0]    Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  rx_state_e state_q, state_d;

  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;

  logic               rx_s, bit_val, bit_rdy, bit_end;
  logic [PRESC_W-1:0] edge_cnt;
  logic               start_det, stop_exit, cnt_clr;
  logic [PRESC_W-1:0] stop_exit_cnt;

  uart_rx_sampler #(
    .PRESC_W (PRESC_W)
  ) u_sampler (
    .clk      (clk),
    .rst      (RST),
    .rx_in    (RX_IN),
    .cnt_clr  (cnt_clr),
    .presc    (presc_q),
    .rx_s     (rx_s),
    .edge_cnt (edge_cnt),
    .bit_val  (bit_val),
    .bit_rdy  (bit_rdy),
    .bit_end  (bit_end)
  );

  // Frame ends the cycle after the stop-bit vote; the rest of the stop bit is not waited out.
  always_comb begin
    stop_exit_cnt = (presc_q >> 1) + PRESC_W'(2);
    start_det     = (state_q == IDLE) && !rx_s;
    stop_exit     = (state_q == STOP) && (edge_cnt == stop_exit_cnt);
    cnt_clr       = (state_q == IDLE) || (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) state_d = START;
      end
      START: begin
        if (bit_rdy && bit_val) state_d = IDLE;
        else if (bit_end)       state_d = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt_q == BCW'(DATA_WIDTH))) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (stop_exit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    p_data_d     = p_data_q;
    presc_d      = presc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_flag_d   = par_flag_q;
    stp_flag_d   = stp_flag_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    busy_d       = (state_d != IDLE);

    // Configuration is frozen for the whole frame at start detect.
    if (start_det) begin
      presc_d    = Prescale;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      bit_cnt_d  = '0;
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
    end

    if ((state_q == DATA) && bit_rdy) begin
      shift_d   = {bit_val, shift_q[DATA_WIDTH-1:1]};
      bit_cnt_d = bit_cnt_q + BCW'(1);
    end

    if ((state_q == PARITY) && bit_rdy && (bit_val != exp_parity(par_typ_q, ^shift_q))) begin
      par_flag_d = 1'b1;
    end

    if ((state_q == STOP) && bit_rdy && !bit_val) begin
      stp_flag_d = 1'b1;
    end

    if (stop_exit) begin
      par_err_d    = par_flag_q;
      stp_err_d    = stp_flag_q;
      data_valid_d = !par_flag_q && !stp_flag_q;
      if (!par_flag_q && !stp_flag_q) p_data_d = shift_q;
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      p_data_q     <= '0;
      presc_q      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_flag_q   <= 1'b0;
      stp_flag_q   <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      p_data_q     <= p_data_d;
      presc_q      <= presc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_flag_q   <= par_flag_d;
      stp_flag_q   <= stp_flag_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;
  assign busy       = busy_q;

endmodule
